// File: rtl/alu_opcodes_pkg.sv
// ALU operation encoding shared by the ALU and every block that drives it.
// Layout is {class, alt, funct3}: class 2'b11 marks compare ops that only produce the flag.
package alu_opcodes_pkg;

  localparam logic [4:0] ALU_ADD  = 5'b00000;
  localparam logic [4:0] ALU_SLL  = 5'b00001;
  localparam logic [4:0] ALU_SLT  = 5'b00010;
  localparam logic [4:0] ALU_SLTU = 5'b00011;
  localparam logic [4:0] ALU_XOR  = 5'b00100;
  localparam logic [4:0] ALU_SRL  = 5'b00101;
  localparam logic [4:0] ALU_OR   = 5'b00110;
  localparam logic [4:0] ALU_AND  = 5'b00111;
  localparam logic [4:0] ALU_SUB  = 5'b01000;
  localparam logic [4:0] ALU_SRA  = 5'b01101;
  localparam logic [4:0] ALU_EQ   = 5'b11000;
  localparam logic [4:0] ALU_NE   = 5'b11001;
  localparam logic [4:0] ALU_LT   = 5'b11100;
  localparam logic [4:0] ALU_GE   = 5'b11101;
  localparam logic [4:0] ALU_LTU  = 5'b11110;
  localparam logic [4:0] ALU_GEU  = 5'b11111;

endpackage

// File: rtl/riscv_pkg.sv
// Core-wide RV32I constants: base opcodes and the ALU issue controller state encoding.
package riscv_pkg;

  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_EXEC = 3'd1,
    ST_WB   = 3'd2,
    ST_BR   = 3'd3,
    ST_ERR  = 3'd4
  } issue_state_e;

endpackage

// File: rtl/riscv_imm_gen.sv
// Combinational RV32I immediate extraction (I, B and U formats), sign-extended to 32 bits.
// Only instruction bits [31:7] carry immediate data, so the opcode field is not an input.
module riscv_imm_gen (
  input  logic [31:7] instr_i,
  output logic [31:0] imm_i_o,
  output logic [31:0] imm_b_o,
  output logic [31:0] imm_u_o
);

  assign imm_i_o = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_b_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                    instr_i[11:8], 1'b0};
  assign imm_u_o = {instr_i[31:12], 12'b0};

endmodule

// File: rtl/riscv_alu_issue_ctrl.sv
// Issues one RV32I ALU-class instruction at a time: decode, regfile read, ALU drive,
// then either a valid/ready writeback, a one-cycle branch resolution or an illegal pulse.
module riscv_alu_issue_ctrl
  import riscv_pkg::*;
  import alu_opcodes_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter bit SKIP_X0 = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            instr_valid_i,
  output logic            instr_ready_o,
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  output logic [4:0]      rs1_addr_o,
  output logic [4:0]      rs2_addr_o,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  output logic [XLEN-1:0] alu_a_o,
  output logic [XLEN-1:0] alu_b_o,
  output logic [4:0]      alu_op_o,
  input  logic [XLEN-1:0] alu_result_i,
  input  logic            alu_flag_i,
  output logic            wb_valid_o,
  input  logic            wb_ready_i,
  output logic [4:0]      wb_addr_o,
  output logic [XLEN-1:0] wb_data_o,
  output logic            br_valid_o,
  output logic            br_taken_o,
  output logic [XLEN-1:0] br_target_o,
  output logic            illegal_o
);

  issue_state_e    state_q, state_d;
  logic [31:0]     instr_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] result_q;
  logic            flag_q;

  logic [31:0] imm_i, imm_b, imm_u;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rd;

  logic            dec_legal, dec_branch;
  logic [XLEN-1:0] dec_a, dec_b;
  logic [4:0]      dec_op;
  logic            accept;

  assign opcode = instr_q[6:0];
  assign rd     = instr_q[11:7];
  assign funct3 = instr_q[14:12];
  assign funct7 = instr_q[31:25];

  riscv_imm_gen u_imm_gen (
    .instr_i (instr_q[31:7]),
    .imm_i_o (imm_i),
    .imm_b_o (imm_b),
    .imm_u_o (imm_u)
  );

  // Decode of the latched instruction; only consumed while in EXEC.
  always_comb begin
    dec_legal  = 1'b0;
    dec_branch = 1'b0;
    dec_a      = '0;
    dec_b      = '0;
    dec_op     = ALU_ADD;
    case (opcode)
      OPC_OP: begin
        dec_a     = rs1_data_i;
        dec_b     = rs2_data_i;
        dec_op    = {1'b0, funct7[5], funct3};
        dec_legal = (funct7 == 7'h00) ||
                    ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
      end
      OPC_OP_IMM: begin
        dec_a = rs1_data_i;
        dec_b = imm_i;
        if (funct3 == 3'b101) begin
          dec_op    = {1'b0, funct7[5], funct3};
          dec_legal = (funct7 == 7'h00) || (funct7 == 7'h20);
        end else if (funct3 == 3'b001) begin
          dec_op    = {2'b00, funct3};
          dec_legal = (funct7 == 7'h00);
        end else begin
          dec_op    = {2'b00, funct3};
          dec_legal = 1'b1;
        end
      end
      OPC_BRANCH: begin
        dec_a      = rs1_data_i;
        dec_b      = rs2_data_i;
        dec_op     = {2'b11, funct3};
        dec_branch = 1'b1;
        dec_legal  = (funct3 != 3'b010) && (funct3 != 3'b011);
      end
      OPC_LUI: begin
        dec_b     = imm_u;
        dec_legal = 1'b1;
      end
      OPC_AUIPC: begin
        dec_a     = pc_q;
        dec_b     = imm_u;
        dec_legal = 1'b1;
      end
      default: ;
    endcase
  end

  // Next-state and output logic; everything idles at zero outside its own state.
  always_comb begin
    state_d       = state_q;
    instr_ready_o = 1'b0;
    rs1_addr_o    = '0;
    rs2_addr_o    = '0;
    alu_a_o       = '0;
    alu_b_o       = '0;
    alu_op_o      = ALU_ADD;
    wb_valid_o    = 1'b0;
    wb_addr_o     = '0;
    wb_data_o     = '0;
    br_valid_o    = 1'b0;
    br_taken_o    = 1'b0;
    br_target_o   = '0;
    illegal_o     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        instr_ready_o = !rst_i;
        if (instr_valid_i) state_d = ST_EXEC;
      end
      ST_EXEC: begin
        rs1_addr_o = instr_q[19:15];
        rs2_addr_o = instr_q[24:20];
        alu_a_o    = dec_a;
        alu_b_o    = dec_b;
        alu_op_o   = dec_op;
        if (!dec_legal)                 state_d = ST_ERR;
        else if (dec_branch)            state_d = ST_BR;
        else if (SKIP_X0 && rd == 5'd0) state_d = ST_IDLE;
        else                            state_d = ST_WB;
      end
      ST_WB: begin
        wb_valid_o = 1'b1;
        wb_addr_o  = rd;
        wb_data_o  = result_q;
        if (wb_ready_i) state_d = ST_IDLE;
      end
      ST_BR: begin
        br_valid_o  = 1'b1;
        br_taken_o  = flag_q;
        br_target_o = pc_q + imm_b;
        state_d     = ST_IDLE;
      end
      ST_ERR: begin
        illegal_o = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign accept = instr_valid_i && instr_ready_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      instr_q  <= '0;
      pc_q     <= '0;
      result_q <= '0;
      flag_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        instr_q <= instr_i;
        pc_q    <= pc_i;
      end
      if (state_q == ST_EXEC) begin
        result_q <= alu_result_i;
        flag_q   <= alu_flag_i;
      end
    end
  end

endmodule
